// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, FSM states
// and default latencies. Optional divider is enabled with `define MDU_DIV_EN.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit with HI/LO registers and fixed multi-cycle latency.
// Define MDU_DIV_EN to build div/divu; otherwise MDOp 2/3 behave as reserved.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      a_reg, a_next;
    logic [31:0]      b_reg, b_next;
    logic             sgn_reg, sgn_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;

    logic [63:0]      prod;
    logic             last;
    logic             is_mul;
    logic             is_div;

    // Sign-extending (or zero-extending) to 64 bits makes one multiplier serve both.
    assign prod = {{32{sgn_reg & a_reg[31]}}, a_reg} * {{32{sgn_reg & b_reg[31]}}, b_reg};

    assign last   = (state_reg != IDLE) && (cnt_reg == CNT_W'(1));
    assign is_mul = (MDOp == MDU_MULT) || (MDOp == MDU_MULTU);

`ifdef MDU_DIV_EN
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Divide magnitudes, then restore signs; 0x80000000 / -1 falls out naturally.
    assign a_neg  = sgn_reg & a_reg[31];
    assign b_neg  = sgn_reg & b_reg[31];
    assign a_mag  = a_neg ? (32'd0 - a_reg) : a_reg;
    assign b_mag  = b_neg ? (32'd0 - b_reg) : b_reg;
    assign q_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    assign is_div = (MDOp == MDU_DIV) || (MDOp == MDU_DIVU);
`else
    assign is_div = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sgn_next   = sgn_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        if (state_reg != IDLE) begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (last) begin
                state_next = IDLE;
                if (state_reg == MULT) begin
                    hi_next = prod[63:32];
                    lo_next = prod[31:0];
                end
`ifdef MDU_DIV_EN
                else if (b_reg != 32'd0) begin
                    hi_next = rem;
                    lo_next = quo;
                end
`endif
            end
        end

        // A new long operation may also launch on the commit edge.
        if (Start && ((state_reg == IDLE) || last)) begin
            if (is_mul || is_div) begin
                a_next     = A;
                b_next     = B;
                sgn_next   = ~MDOp[0];
                state_next = is_mul ? MULT : DIV;
                cnt_next   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (state_reg == IDLE) begin
                if (MDOp == MDU_MTHI) hi_next = A;
                if (MDOp == MDU_MTLO) lo_next = A;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sgn_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sgn_reg   <= sgn_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign Busy = (state_reg != IDLE);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit; expectations follow whether
// MDU_DIV_EN is defined for the build.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;
    int n;

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("%s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        #2;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // mult -3 * 5
        issue(MDU_MULT, 32'hFFFFFFFD, 32'd5);
        check("mult_busy_start", {31'd0, Busy}, 32'd1);
        wait_idle(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFF1);
        $display("txn mult  cycles=%0d HI=%08h LO=%08h", n, HI, LO);

        // multu 0xFFFFFFFF * 2
        issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);
        $display("txn multu cycles=%0d HI=%08h LO=%08h", n, HI, LO);

        // div -7 / 2
        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        check("div_cycles", n, DIV_ON ? 32'd10 : 32'd0);
        check("div_hi", HI, DIV_ON ? 32'hFFFFFFFF : 32'h00000001);
        check("div_lo", LO, DIV_ON ? 32'hFFFFFFFD : 32'hFFFFFFFE);
        $display("txn div   cycles=%0d HI=%08h LO=%08h", n, HI, LO);

        // reserved op: no effect
        issue(3'd6, 32'h55555555, 32'h0);
        check("rsvd_busy", {31'd0, Busy}, 32'd0);
        check("rsvd_lo", LO, DIV_ON ? 32'hFFFFFFFD : 32'hFFFFFFFE);
        $display("txn rsvd  Busy=%0b HI=%08h LO=%08h", Busy, HI, LO);

        // mthi / mtlo, single-edge
        issue(MDU_MTHI, 32'h12345678, 32'h0);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        check("mthi_hi", HI, 32'h12345678);
        issue(MDU_MTLO, 32'h9ABCDEF0, 32'h0);
        check("mtlo_busy", {31'd0, Busy}, 32'd0);
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        check("mtlo_hi_kept", HI, 32'h12345678);
        $display("txn mthi/mtlo HI=%08h LO=%08h", HI, LO);

        // divu by zero: full latency, HI/LO unchanged
        issue(MDU_DIVU, 32'd77, 32'd0);
        wait_idle(n);
        check("divz_cycles", n, DIV_ON ? 32'd10 : 32'd0);
        check("divz_hi", HI, 32'h12345678);
        check("divz_lo", LO, 32'h9ABCDEF0);
        $display("txn divu0 cycles=%0d HI=%08h LO=%08h", n, HI, LO);

        // signed overflow 0x80000000 / -1
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        check("ovf_hi", HI, DIV_ON ? 32'h00000000 : 32'h12345678);
        check("ovf_lo", LO, DIV_ON ? 32'h80000000 : 32'h9ABCDEF0);
        $display("txn divov cycles=%0d HI=%08h LO=%08h", n, HI, LO);

        // mult 3*4 with an ignored mtlo while busy
        issue(MDU_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        issue(MDU_MTLO, 32'h0000DEAD, 32'h0);
        check("mtlo_ign_busy", {31'd0, Busy}, 32'd1);
        check("mtlo_ign_lo", LO, DIV_ON ? 32'h80000000 : 32'h9ABCDEF0);
        wait_idle(n);
        check("mtlo_ign_cycles", n, 32'd3);
        check("mtlo_ign_hi", HI, 32'h00000000);
        check("mtlo_ign_final_lo", LO, 32'h0000000C);
        $display("txn mult+mtlo cycles=%0d HI=%08h LO=%08h", n, HI, LO);

        // back-to-back: multu issued on the commit edge of mult
        issue(MDU_MULT, 32'd7, 32'd6);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(MDU_MULTU, 32'd2, 32'd3);
        check("b2b_busy", {31'd0, Busy}, 32'd1);
        check("b2b_first_lo", LO, 32'h0000002A);
        wait_idle(n);
        check("b2b_cycles", n, 32'd5);
        check("b2b_second_lo", LO, 32'h00000006);
        $display("txn b2b   cycles=%0d HI=%08h LO=%08h", n, HI, LO);

        // asynchronous reset mid-operation (counter at 4)
        if (DIV_ON) begin
            issue(MDU_DIV, 32'd100, 32'd7);
            repeat (6) begin
                @(posedge clk);
                #1;
            end
        end else begin
            issue(MDU_MULT, 32'd3, 32'd4);
            @(posedge clk);
            #1;
        end
        check("abort_busy_pre", {31'd0, Busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_commit_busy", {31'd0, Busy}, 32'd0);
        check("abort_no_commit_lo", LO, 32'd0);
        check("abort_no_commit_hi", HI, 32'd0);
        $display("txn abort Busy=%0b HI=%08h LO=%08h", Busy, HI, LO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the MIPS datapath: consumes the two register-file read ports as operands and holds the HI/LO result registers. mfhi/mflo results return to the register-file write-data mux outside this block. The unit models fixed multi-cycle latency with a Busy flag. The control unit uses Busy to stall any following HI/LO-touching instruction.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- Start  input  1  issue the operation on MDOp this cycle
- MDOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 reserved
- A  input  32  operand rs (register-file read port 1)
- B  input  32  operand rt (register-file read port 2)
- Busy  output  1  long operation in progress
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, MULT, DIV. Registered counter of width clog2(max(MULT_CYCLES, DIV_CYCLES) + 1).
- IDLE with Start=1:
  - MDOp 0/1: latch A, B and the signedness; load the counter with MULT_CYCLES; go to MULT.
  - MDOp 2/3: same, loading DIV_CYCLES; go to DIV.
  - MDOp 4: HI <= A at this edge; stay in IDLE.
  - MDOp 5: LO <= A at this edge; stay in IDLE.
  - MDOp 6/7: no effect.
- MULT/DIV: decrement the counter each edge. At the edge where the counter goes 1→0, commit the result to HI/LO and return to IDLE.
- Start while Busy=1 is ignored, including mthi/mtlo. HI/LO do not change until commit. The control unit must not assert Start while Busy.
- Arithmetic is computed from the latched operands only. A/B changing while busy has no effect.
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero: the full DIV_CYCLES busy period still runs. HI and LO are left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Busy = (state != IDLE), driven from the state register, not from Start.

## Timing
- Reset (asynchronous, any time): state=IDLE, counter=0, Busy=0, HI=0, LO=0, latched operands=0.
- Reset mid-operation aborts without a commit.
- Start sampled at edge k:
  - Busy=1 from just after edge k.
  - Result visible on HI/LO and Busy=0 just after edge k+N, where N is MULT_CYCLES or DIV_CYCLES. Busy is high exactly N cycles.
- Start may be reasserted at edge k+N, back-to-back with the commit. The new operation is accepted and Busy stays high.
- mthi/mtlo have single-edge latency and never raise Busy.
- HI/LO outputs are plain register outputs; mfhi/mflo read them combinationally.

## Configuration
- MDU_DIV_EN defined: div/divu are implemented as above.
- MDU_DIV_EN undefined: MDOp 2/3 are treated as reserved, so Start has no effect, Busy stays 0 and HI/LO are unchanged. The divider logic and the DIV state are not synthesised.

## Structure
- Shared package mdu_pkg holds:
  - MDOp encoding constants: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - the state enum: IDLE, MULT, DIV.
- Default cycle constants: MDU_MULT_CYCLES=5, MDU_DIV_CYCLES=10.
- No sub-module. Product and quotient/remainder use behavioural operators on the latched operands, inside the single module.

## Test plan
- Start mult with A=0xFFFFFFFD (−3), B=5 → Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Start multu with A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- Start div with A=0xFFFFFFF9 (−7), B=2 → Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Sequence:
  - mthi A=0x12345678, then mtlo A=0x9ABCDEF0 → HI/LO updated one edge each, Busy stays 0.
  - Then divu with B=0 → Busy 10 cycles; HI/LO still 0x12345678/0x9ABCDEF0.
- Start mult (A=3, B=4), then Start mtlo A=0xDEAD on cycle 2 → mtlo ignored; final HI=0, LO=0x0000000C.
- Start div (A=100, B=7), then assert reset asynchronously mid-cycle at count 4 → Busy, HI and LO drop to 0 immediately; no later commit.
